// File: rtl/imem_loader_if.sv
// Byte-stream handshake and program-memory write bus between the loader
// (slave) and the stream source / program memory (master).
interface imem_loader_if #(
  parameter int ADDR_W = 5
);
  logic              byte_valid;
  logic [7:0]        byte_data;
  logic              byte_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;

  modport master (
    output byte_valid, byte_data,
    input  byte_ready, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  byte_valid, byte_data,
    output byte_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/imem_loader.sv
// Program-load controller: framed byte stream -> little-endian 32-bit words
// written to program memory; core held until a checksum-verified image exists.
module imem_loader #(
  parameter int DEPTH  = 32,
  parameter int ADDR_W = 5
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  imem_loader_if.slave   bus,
  output logic           busy,
  output logic           done,
  output logic           error,
  output logic           core_hold
);

  localparam int             IDX_W   = ADDR_W + 1;
  localparam logic [8:0]     DEPTH_9 = 9'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE, S_HDR, S_DATA, S_WRITE, S_CSUM, S_DONE, S_ERR
  } state_t;

  state_t           state;
  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] n_words;
  logic [IDX_W-1:0] idx_next;
  logic [1:0]       lane;
  logic [7:0]       csum;
  logic [23:0]      word_lo;
  logic             xfer;
  logic             hdr_bad;

  always_comb begin
    bus.byte_ready = (state == S_HDR) || (state == S_DATA) || (state == S_CSUM);
    xfer           = bus.byte_valid && bus.byte_ready;
    idx_next       = idx + 1'b1;
    hdr_bad        = (bus.byte_data == 8'd0) || ({1'b0, bus.byte_data} > DEPTH_9);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      idx           <= '0;
      n_words       <= '0;
      lane          <= '0;
      csum          <= '0;
      word_lo       <= '0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      error         <= 1'b0;
      core_hold     <= 1'b1;
    end else begin
      case (state)
        S_IDLE, S_DONE, S_ERR: begin
          if (start) begin
            state     <= S_HDR;
            idx       <= '0;
            lane      <= '0;
            csum      <= '0;
            busy      <= 1'b1;
            done      <= 1'b0;
            error     <= 1'b0;
            core_hold <= 1'b1;
          end
        end

        S_HDR: begin
          if (xfer) begin
            if (hdr_bad) begin
              state <= S_ERR;
              busy  <= 1'b0;
              error <= 1'b1;
            end else begin
              // Header already bounded by DEPTH, so it fits the index width.
              n_words <= IDX_W'(bus.byte_data);
              state   <= S_DATA;
            end
          end
        end

        S_DATA: begin
          if (xfer) begin
            csum <= csum ^ bus.byte_data;
            lane <= lane + 1'b1;
            // Top lane goes straight to the write register with the lower three.
            case (lane)
              2'd0: word_lo[7:0]   <= bus.byte_data;
              2'd1: word_lo[15:8]  <= bus.byte_data;
              2'd2: word_lo[23:16] <= bus.byte_data;
              default: begin
                state         <= S_WRITE;
                bus.mem_we    <= 1'b1;
                bus.mem_addr  <= idx[ADDR_W-1:0];
                bus.mem_wdata <= {bus.byte_data, word_lo};
              end
            endcase
          end
        end

        S_WRITE: begin
          bus.mem_we <= 1'b0;
          idx        <= idx_next;
          state      <= (idx_next == n_words) ? S_CSUM : S_DATA;
        end

        S_CSUM: begin
          if (xfer) begin
            busy <= 1'b0;
            if (bus.byte_data == csum) begin
              state     <= S_DONE;
              done      <= 1'b1;
              core_hold <= 1'b0;
            end else begin
              state <= S_ERR;
              error <= 1'b1;
            end
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: table vectors, hand-built corner sequences and
// randomized frames checked against a frame-level reference model.
module tb_imem_loader;

  localparam int DEPTH  = 32;
  localparam int ADDR_W = 5;

  typedef logic [7:0] byte_q_t[$];

  typedef struct {
    logic [7:0]  b[12];
    int          len;
    int          prob;
    int          exp_cons;
    logic        exp_done;
    logic        exp_err;
    int          exp_nw;
    logic [31:0] w0;
    logic [31:0] w1;
  } vec_t;

  typedef struct {
    int          addr;
    logic [31:0] data;
  } wr_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic busy, done, error, core_hold;

  imem_loader_if #(.ADDR_W(ADDR_W)) bus ();

  imem_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .bus       (bus),
    .busy      (busy),
    .done      (done),
    .error     (error),
    .core_hold (core_hold)
  );

  always #5 clk = ~clk;

  int tests  = 0;
  int failed = 0;

  logic [31:0] tb_mem [DEPTH];
  logic [31:0] exp_mem[DEPTH];
  wr_t         dut_writes[$];
  logic [31:0] exp_words[$];
  int          exp_consumed;
  logic        exp_done, exp_err;
  logic        prev_we = 1'b0;
  int          we_double = 0;
  int          we_ready  = 0;

  function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endfunction

  // Program memory model plus write-strobe discipline, sampled mid-cycle.
  always @(negedge clk) begin
    if (bus.mem_we === 1'b1) begin
      dut_writes.push_back('{addr: int'(bus.mem_addr), data: bus.mem_wdata});
      if (int'(bus.mem_addr) < DEPTH) tb_mem[bus.mem_addr] = bus.mem_wdata;
      if (prev_we) we_double++;
      if (bus.byte_ready) we_ready++;
    end
    prev_we = (bus.mem_we === 1'b1);
  end

  // Reference model: interprets a whole frame by the framing rules.
  task automatic run_model(input byte_q_t f);
    int n;
    logic [7:0] x;
    logic [31:0] w;
    n = int'(f[0]);
    exp_words.delete();
    exp_done = 1'b0;
    exp_err  = 1'b0;
    if (n == 0 || n > DEPTH) begin
      exp_consumed = 1;
      exp_err = 1'b1;
    end else begin
      x = 8'h00;
      for (int k = 0; k < n; k++) begin
        w = 32'h0;
        for (int j = 0; j < 4; j++) begin
          w = w + (32'(f[1 + 4*k + j]) << (8*j));
          x = x ^ f[1 + 4*k + j];
        end
        exp_words.push_back(w);
        exp_mem[k] = w;
      end
      exp_consumed = 2 + 4*n;
      if (f[1 + 4*n] == x) exp_done = 1'b1;
      else                 exp_err  = 1'b1;
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send(input byte_q_t f, input int prob, output int consumed);
    int i = 0;
    int cyc = 0;
    while (i < f.size() && cyc < 4000) begin
      if (i > 0 && !busy) break;
      bus.byte_valid = ($urandom_range(99) < prob);
      bus.byte_data  = f[i];
      if (bus.byte_valid && bus.byte_ready) i++;
      @(negedge clk);
      cyc++;
    end
    bus.byte_valid = 1'b0;
    if (cyc >= 4000) check("send_timeout", 1, 0);
    consumed = i;
  endtask

  task automatic check_result(string tag, int consumed);
    check({tag, "_consumed"}, consumed, exp_consumed);
    check({tag, "_done"}, done, exp_done);
    check({tag, "_error"}, error, exp_err);
    check({tag, "_core_hold"}, core_hold, !exp_done);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_nwrites"}, dut_writes.size(), exp_words.size());
    for (int k = 0; k < dut_writes.size() && k < exp_words.size(); k++) begin
      check({tag, "_waddr"}, dut_writes[k].addr, k);
      check({tag, "_wdata"}, dut_writes[k].data, exp_words[k]);
    end
    begin
      int bad = 0;
      for (int k = 0; k < DEPTH; k++) if (tb_mem[k] !== exp_mem[k]) bad++;
      check({tag, "_mem_image"}, bad, 0);
    end
    // Source keeps offering bytes; nothing may be accepted afterwards.
    begin
      int rdy = 0;
      bus.byte_valid = 1'b1;
      bus.byte_data  = 8'h5A;
      for (int k = 0; k < 3; k++) begin
        if (bus.byte_ready) rdy++;
        @(negedge clk);
      end
      bus.byte_valid = 1'b0;
      check({tag, "_ready_after"}, rdy, 0);
    end
  endtask

  task automatic run_frame(string tag, input byte_q_t f, input int prob);
    int c;
    pulse_start();
    dut_writes.delete();
    run_model(f);
    send(f, prob, c);
    check_result(tag, c);
  endtask

  vec_t    vecs[5];
  byte_q_t good2;

  initial begin
    bus.byte_valid = 1'b0;
    bus.byte_data  = 8'h00;
    for (int k = 0; k < DEPTH; k++) begin
      tb_mem[k]  = 32'hDEAD_0000 + 32'(k);
      exp_mem[k] = 32'hDEAD_0000 + 32'(k);
    end
    good2 = '{8'h02, 8'h13, 8'h00, 8'h50, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00, 8'hC0};

    vecs[0] = '{b: '{8'h02,8'h13,8'h00,8'h50,8'h00,8'h93,8'h00,8'h10,8'h00,8'hC0,8'h00,8'h00},
                len: 10, prob: 100, exp_cons: 10, exp_done: 1, exp_err: 0, exp_nw: 2,
                w0: 32'h0050_0013, w1: 32'h0010_0093};
    vecs[1] = '{b: '{8'h02,8'h13,8'h00,8'h50,8'h00,8'h93,8'h00,8'h10,8'h00,8'hC1,8'h00,8'h00},
                len: 10, prob: 100, exp_cons: 10, exp_done: 0, exp_err: 1, exp_nw: 2,
                w0: 32'h0050_0013, w1: 32'h0010_0093};
    vecs[2] = '{b: '{8'h00,8'hAA,8'hBB,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00},
                len: 3, prob: 100, exp_cons: 1, exp_done: 0, exp_err: 1, exp_nw: 0,
                w0: 32'h0, w1: 32'h0};
    vecs[3] = '{b: '{8'h21,8'h11,8'h22,8'h33,8'h44,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00},
                len: 5, prob: 100, exp_cons: 1, exp_done: 0, exp_err: 1, exp_nw: 0,
                w0: 32'h0, w1: 32'h0};
    vecs[4] = '{b: '{8'h01,8'h13,8'h00,8'h50,8'h00,8'h43,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00},
                len: 6, prob: 50, exp_cons: 6, exp_done: 1, exp_err: 0, exp_nw: 1,
                w0: 32'h0050_0013, w1: 32'h0};

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_byte_ready", bus.byte_ready, 0);
    check("rst_mem_we", bus.mem_we, 0);
    check("rst_mem_addr", bus.mem_addr, 0);
    check("rst_mem_wdata", bus.mem_wdata, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_error", error, 0);
    check("rst_core_hold", core_hold, 1);
    rst = 1'b0;
    @(negedge clk);
    check("idle_core_hold", core_hold, 1);
    check("idle_ready", bus.byte_ready, 0);

    // Table vectors
    for (int v = 0; v < 5; v++) begin
      byte_q_t f;
      int c;
      f.delete();
      for (int k = 0; k < vecs[v].len; k++) f.push_back(vecs[v].b[k]);
      pulse_start();
      check("start_busy", busy, 1);
      check("start_core_hold", core_hold, 1);
      dut_writes.delete();
      run_model(f);
      send(f, vecs[v].prob, c);
      check("vec_consumed", c, vecs[v].exp_cons);
      check("vec_done", done, vecs[v].exp_done);
      check("vec_error", error, vecs[v].exp_err);
      check("vec_nwrites", dut_writes.size(), vecs[v].exp_nw);
      if (vecs[v].exp_nw > 0 && dut_writes.size() > 0) check("vec_w0", dut_writes[0].data, vecs[v].w0);
      if (vecs[v].exp_nw > 1 && dut_writes.size() > 1) check("vec_w1", dut_writes[1].data, vecs[v].w1);
      check_result("vec", c);
    end

    // Reset after the 3rd data byte of word 1
    begin
      byte_q_t part;
      int c;
      part = '{8'h02, 8'h13, 8'h00, 8'h50, 8'h00, 8'h93, 8'h00, 8'h10};
      pulse_start();
      send(part, 100, c);
      check("partial_consumed", c, 8);
      exp_mem[0] = 32'h0050_0013;
      rst = 1'b1;
      @(negedge clk);
      check("midrst_byte_ready", bus.byte_ready, 0);
      check("midrst_mem_we", bus.mem_we, 0);
      check("midrst_mem_addr", bus.mem_addr, 0);
      check("midrst_mem_wdata", bus.mem_wdata, 0);
      check("midrst_busy", busy, 0);
      check("midrst_done", done, 0);
      check("midrst_error", error, 0);
      check("midrst_core_hold", core_hold, 1);
      rst = 1'b0;
      @(negedge clk);
      run_frame("after_rst", good2, 100);
    end

    // start pulsed during DATA is ignored
    begin
      byte_q_t qa, qb;
      int c;
      qa = good2[0:2];
      qb = good2[3:$];
      pulse_start();
      dut_writes.delete();
      run_model(good2);
      send(qa, 100, c);
      pulse_start();
      check("start_in_data_busy", busy, 1);
      send(qb, 100, c);
      check_result("start_in_data", c + 3);
    end

    // start in DONE re-arms the loader
    check("pre_done", done, 1);
    pulse_start();
    check("redo_done", done, 0);
    check("redo_core_hold", core_hold, 1);
    check("redo_busy", busy, 1);
    check("redo_ready", bus.byte_ready, 1);
    run_frame("redo", good2, 100);

    // Randomized frames
    for (int r = 0; r < 20; r++) begin
      byte_q_t f;
      int n;
      logic [7:0] x;
      logic [7:0] d;
      if (r == 0)                         n = DEPTH;
      else if ($urandom_range(7) == 0)    n = ($urandom_range(1) == 0) ? 0 : $urandom_range(DEPTH + 1, 255);
      else                                n = $urandom_range(1, DEPTH);
      f.delete();
      f.push_back(8'(n));
      if (n == 0 || n > DEPTH) begin
        for (int k = 0; k < 4; k++) f.push_back(8'($urandom));
      end else begin
        x = 8'h00;
        for (int k = 0; k < 4*n; k++) begin
          d = 8'($urandom);
          f.push_back(d);
          x = x ^ d;
        end
        if ($urandom_range(3) == 0) x = x ^ 8'($urandom_range(1, 255));
        f.push_back(x);
      end
      run_frame("rand", f, $urandom_range(30, 100));
    end

    check("we_single_cycle", we_double, 0);
    check("we_ready_low", we_ready, 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL global_timeout: got timeout, expected completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/imem_loader.md
# imem_loader

Upstream program-load controller for the pipelined RISC-V core. It replaces simulation-only file loading of program memory with a synthesizable path. It accepts a framed byte stream over a valid/ready handshake and assembles little-endian 32-bit instruction words. It writes those words into the core's program memory and holds the core stalled until a checksum-verified image is in place.

## Interface
- DEPTH, 32, program memory depth in words (index range 0..DEPTH-1)
- ADDR_W, 5, width of the word address; must satisfy 2^ADDR_W >= DEPTH
- clk  in  1  single clock; all state updates on the rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle request to begin a load; honoured only in IDLE, DONE, ERR
- byte_valid  in  1  source has a byte on byte_data
- byte_data  in  8  stream byte
- byte_ready  out  1  loader can accept a byte this cycle; reset 0
- mem_we  out  1  program memory write strobe, one cycle per word; reset 0
- mem_addr  out  ADDR_W  word index for the write; reset 0
- mem_wdata  out  32  assembled instruction word; reset 0
- busy  out  1  high in HDR, DATA, WRITE, CSUM; reset 0
- done  out  1  sticky: image loaded and checksum matched; reset 0
- error  out  1  sticky: bad header or checksum mismatch; reset 0
- core_hold  out  1  keeps the core's PC and fetch stalled; reset 1; low only in DONE

## Operation
- Frame layout: 1 header byte N (word count), then 4*N data bytes (LSB first per word), then 1 checksum byte equal to the XOR of all 4*N data bytes.
- A byte transfers on an edge where byte_valid && byte_ready. byte_ready is driven combinationally from the state and is high exactly in HDR, DATA, CSUM.
- IDLE: on start, clear byte count, word index and running XOR, then go to HDR. Sets core_hold=1 and clears done and error.
- HDR: on transfer, latch N. If N==0 or N>DEPTH, go to ERR with no memory writes. Otherwise go to DATA.
- DATA: on transfer, shift the byte into the word register at lane byte_cnt (0..3) and XOR it into the checksum. When the 4th byte transfers, go to WRITE.
- WRITE: mem_we=1, mem_addr=word index, mem_wdata=assembled word, for exactly one cycle. Then increment the index; go to CSUM if index==N, otherwise go to DATA.
- CSUM: on transfer, compare the byte with the running XOR. On a match go to DONE; on a mismatch go to ERR.
- DONE: done=1 and core_hold=0. ERR: error=1 and core_hold=1. Both states persist until start or rst.
- start in any busy state is ignored. byte_valid in IDLE, WRITE, DONE, ERR is not consumed.
- Words at index >= N are never written; their previous contents are untouched.
- rst mid-load: return to IDLE on the next edge and restore all outputs to their reset values. Memory already written is left as-is; the core stays held because core_hold=1.
- Arithmetic: the word index counter is ADDR_W+1 bits so that index==DEPTH is representable without wrap. Byte lane counter is 2 bits and wraps 3->0.

## Timing
- Header transfer at edge k: state is DATA, or ERR, from cycle k+1.
- 4th byte of a word at edge k: mem_we high during cycle k+1, with byte_ready low; the next data byte can transfer at edge k+2 at the earliest.
- Minimum frame time for N words: 1 + 5N + 1 transfer cycles plus 1 cycle of start latency.
- Checksum transfer at edge k: done or error is high and core_hold updated from cycle k+1.
- Source stalls (byte_valid low) of any length preserve all state; no timeout.

## Test plan
- N=2 with bytes 02,13,00,50,00,93,00,10,00,C0 and valid held high -> writes 0x00500013@0 then 0x00100093@1, each mem_we one cycle; done=1 and core_hold=0 the cycle after C0.
- Same frame with checksum byte C1 -> both words written, error=1, done=0, core_hold stays 1.
- Header 00, then header 33 (DEPTH=32) -> ERR after the header, mem_we never asserted, remaining bytes not consumed.
- N=1 with byte_valid toggling randomly -> word 0x00500013 written once, byte_ready low in the WRITE cycle, done=1.
- rst asserted after the 3rd data byte of word 1 -> next cycle all outputs are at reset values (core_hold=1). A fresh start and full frame then loads correctly.
- start pulsed while in DATA -> ignored, and the load completes normally. start in DONE -> done cleared, core_hold=1, state HDR.
